// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types for the pipeline stall/flush controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_e;

    // Active-low hold per pipeline register plus the clears the controller drives
    typedef struct packed {
        logic pc_en_n;
        logic if_id_en_n;
        logic id_ex_en_n;
        logic ex_mem_en_n;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } stage_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
module hazard_detect #(
    parameter int RegW = 5
) (
    input  logic [RegW-1:0] id_rs1,
    input  logic [RegW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RegW-1:0] ex_rd,
    input  logic            ex_is_load,
    output logic            load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired zero, so a load into it never produces a hazard
    assign load_use = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller with memory-wait timeout and stall counter
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RegW    = 5,
    parameter int MaxWait = 15,
    parameter int CntW    = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [RegW-1:0] id_rs1_i,
    input  logic [RegW-1:0] id_rs2_i,
    input  logic            id_use_rs1_i,
    input  logic            id_use_rs2_i,
    input  logic [RegW-1:0] ex_rd_i,
    input  logic            ex_is_load_i,
    input  logic            ex_br_taken_i,
    input  logic            mem_req_i,
    input  logic            mem_ack_i,
    output logic            pc_en_no,
    output logic            if_id_en_no,
    output logic            id_ex_en_no,
    output logic            ex_mem_en_no,
    output logic            if_id_flush_o,
    output logic            id_ex_flush_o,
    output logic            mem_wb_flush_o,
    output logic            err_o,
    output logic [CntW-1:0] stall_cnt_o
);

    localparam int WcW = $clog2(MaxWait + 1);

    hz_state_e      state_q, state_d;
    logic [WcW-1:0] wcnt_q, wcnt_d;
    logic [CntW-1:0] stall_cnt_q;
    logic           err_q;
    logic           load_use;
    logic           mem_wait;
    stage_ctrl_t    ctrl;

    hazard_detect #(
        .RegW (RegW)
    ) u_hazard_detect (
        .id_rs1     (id_rs1_i),
        .id_rs2     (id_rs2_i),
        .id_use_rs1 (id_use_rs1_i),
        .id_use_rs2 (id_use_rs2_i),
        .ex_rd      (ex_rd_i),
        .ex_is_load (ex_is_load_i),
        .load_use   (load_use)
    );

    assign mem_wait = mem_req_i && !mem_ack_i;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    if (wcnt_q == WcW'(MaxWait - 1)) begin
                        state_d = ERR;
                    end else begin
                        state_d = MEM_WAIT;
                        wcnt_d  = wcnt_q + 1'b1;
                    end
                end else begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    // Priority: reset > error > memory wait > branch > load-use > normal
    always_comb begin
        ctrl = '0;
        if (!rst_ni) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (state_q == ERR) begin
            ctrl.pc_en_n     = 1'b1;
            ctrl.if_id_en_n  = 1'b1;
            ctrl.id_ex_en_n  = 1'b1;
            ctrl.ex_mem_en_n = 1'b1;
        end else if (mem_wait) begin
            ctrl.pc_en_n      = 1'b1;
            ctrl.if_id_en_n   = 1'b1;
            ctrl.id_ex_en_n   = 1'b1;
            ctrl.ex_mem_en_n  = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (ex_br_taken_i) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_en_n     = 1'b1;
            ctrl.if_id_en_n  = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_q || (state_d == ERR);
            if (ctrl.pc_en_n && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign pc_en_no       = ctrl.pc_en_n;
    assign if_id_en_no    = ctrl.if_id_en_n;
    assign id_ex_en_no    = ctrl.id_ex_en_n;
    assign ex_mem_en_no   = ctrl.ex_mem_en_n;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_flush_o  = ctrl.id_ex_flush;
    assign mem_wb_flush_o = ctrl.mem_wb_flush;
    assign err_o          = err_q && rst_ni;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int RW   = 5;
    localparam int MW   = 4;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          use1, use2, ld, br, req, ack;
    logic          pc_en_no, if_id_en_no, id_ex_en_no, ex_mem_en_no;
    logic          if_id_flush, id_ex_flush, mem_wb_flush, err_o;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .RegW    (RW),
        .MaxWait (MW),
        .CntW    (CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_use_rs1_i   (use1),
        .id_use_rs2_i   (use2),
        .ex_rd_i        (ex_rd),
        .ex_is_load_i   (ld),
        .ex_br_taken_i  (br),
        .mem_req_i      (req),
        .mem_ack_i      (ack),
        .pc_en_no       (pc_en_no),
        .if_id_en_no    (if_id_en_no),
        .id_ex_en_no    (id_ex_en_no),
        .ex_mem_en_no   (ex_mem_en_no),
        .if_id_flush_o  (if_id_flush),
        .id_ex_flush_o  (id_ex_flush),
        .mem_wb_flush_o (mem_wb_flush),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt)
    );

    // {pc,if_id,id_ex,ex_mem holds, if_id,id_ex,mem_wb flushes, err, stall count}
    typedef logic [7+1+CW-1:0] obs_t;

    obs_t exp_q[$];
    obs_t act;
    int   n_cmp = 0;
    int   n_bad = 0;

    bit   m_err;
    int   m_waits;
    int   m_cnt;

    assign act = {pc_en_no, if_id_en_no, id_ex_en_no, ex_mem_en_no,
                  if_id_flush, id_ex_flush, mem_wb_flush, err_o, stall_cnt};

    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL ctrl_obs t=%0t: actual=%b required=%b", $time, act, e);
            end
        end
    end

    task automatic cycle(input bit r, input int rs1, input int rs2, input bit u1, input bit u2,
                         input int rd, input bit l, input bit b, input bit q, input bit a);
        obs_t          e;
        bit            lu;
        bit            hold;
        logic [CW-1:0] c;
        rst_ni = r;
        id_rs1 = rs1[RW-1:0];
        id_rs2 = rs2[RW-1:0];
        use1   = u1;
        use2   = u2;
        ex_rd  = rd[RW-1:0];
        ld     = l;
        br     = b;
        req    = q;
        ack    = a;
        c      = m_cnt[CW-1:0];
        lu     = l && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (!r)             e = {4'b0000, 3'b111, 1'b0, c};
        else if (m_err)     e = {4'b1111, 3'b000, 1'b1, c};
        else if (q && !a)   e = {4'b1111, 3'b001, 1'b0, c};
        else if (b)         e = {4'b0000, 3'b110, 1'b0, c};
        else if (lu)        e = {4'b1100, 3'b010, 1'b0, c};
        else                e = {4'b0000, 3'b000, 1'b0, c};
        hold = r && (m_err || (q && !a) || (!b && lu));
        exp_q.push_back(e);
        @(posedge clk);
        if (!r) begin
            m_err   = 0;
            m_waits = 0;
            m_cnt   = 0;
        end else begin
            if (hold) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (!m_err) begin
                if (q && !a) begin
                    m_waits++;
                    if (m_waits >= MW) m_err = 1;
                end else begin
                    m_waits = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input bit r);
        cycle(r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int ack_pct;
        rst_ni = 1'b0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        use1 = 0; use2 = 0; ld = 0; br = 0; req = 0; ack = 0;
        m_err = 0; m_waits = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;

        idle(0);
        // load-use on rs2, then x0 and unused-operand non-hazards
        cycle(1, 0, 5, 0, 1, 5, 1, 0, 0, 0);
        idle(1);
        cycle(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        cycle(1, 0, 5, 1, 0, 5, 1, 0, 0, 0);
        // branch overrides load-use
        cycle(1, 5, 0, 1, 0, 5, 1, 1, 0, 0);
        // 3-cycle memory wait with a pending branch, honoured on ack
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle(1);
        // timeout to sticky error, cleared only by reset
        repeat (6) cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(0);
        idle(1);
        // reset in the middle of a wait
        repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        // counter saturation
        repeat (9) cycle(1, 3, 0, 1, 0, 3, 1, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            ack_pct = ((i / 200) % 2 == 0) ? 50 : 8;
            cycle($urandom_range(0, 59) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < ack_pct);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
